ps_axl_master: RTL



---
 rtl/ps_axl_pkg.sv | 22 ++
 rtl/ps_axl_master.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/ps_axl_pkg.sv
// Shared types and constants for the ps-to-AXI-lite master.
package ps_axl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_DATA,
    RSP
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  function automatic logic [63:0] sat_max(input int unsigned w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/ps_axl_master.sv
// Single-outstanding AXI-lite master driven by a valid/ready command port,
// returning read data / write status with a saturating latency count.
module ps_axl_master
  import ps_axl_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [CNT_WIDTH-1:0]  rsp_cycles,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic                  wavalid,
  input  logic                  waready,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [DATA_WIDTH-1:0] wresp,
  input  logic                  bvalid,
  output logic                  bready,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic                  rvalid,
  output logic                  rready
);

  localparam logic [63:0]          CNT_MAX_W = sat_max(CNT_WIDTH);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = CNT_MAX_W[CNT_WIDTH-1:0];

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_WIDTH'(1);
  endfunction

  state_e                state, state_d;
  logic                  cmd_ready_d, wavalid_d, wvalid_d, bready_d;
  logic                  arvalid_d, rready_d, rsp_valid_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  accept, busy, b_hs, r_hs;
  logic                  unused_wresp_hi;

  assign accept = cmd_valid && cmd_ready;
  assign busy   = (state == WR_REQ) || (state == WR_RESP) ||
                  (state == RD_REQ) || (state == RD_DATA);
  assign b_hs   = (state == WR_RESP) && bvalid && bready;
  assign r_hs   = (state == RD_DATA) && rvalid && rready;
  assign waddr  = addr_q;
  assign raddr  = addr_q;
  assign unused_wresp_hi = ^wresp[DATA_WIDTH-1:2];

  always_comb begin
    state_d     = state;
    cmd_ready_d = 1'b0;
    wavalid_d   = 1'b0;
    wvalid_d    = 1'b0;
    bready_d    = 1'b0;
    arvalid_d   = 1'b0;
    rready_d    = 1'b0;
    rsp_valid_d = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (accept) begin
          cmd_ready_d = 1'b0;
          if (cmd_write) begin
            state_d   = WR_REQ;
            wavalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RD_REQ;
            arvalid_d = 1'b1;
          end
        end
      end
      WR_REQ: begin
        // AW and W retire independently; B is requested once both are gone
        wavalid_d = wavalid && !waready;
        wvalid_d  = wvalid && !wready;
        if (!wavalid_d && !wvalid_d) begin
          state_d  = WR_RESP;
          bready_d = 1'b1;
        end
      end
      WR_RESP: begin
        bready_d = 1'b1;
        if (bvalid) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end
      end
      RD_REQ: begin
        arvalid_d = 1'b1;
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        rready_d = 1'b1;
        if (rvalid) begin
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end
      end
      RSP: begin
        rsp_valid_d = 1'b1;
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cmd_ready  <= 1'b0;
      wavalid    <= 1'b0;
      wvalid     <= 1'b0;
      bready     <= 1'b0;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      rsp_valid  <= 1'b0;
      addr_q     <= '0;
      wdata      <= '0;
      rsp_write  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      rsp_cycles <= '0;
    end else begin
      state     <= state_d;
      cmd_ready <= cmd_ready_d;
      wavalid   <= wavalid_d;
      wvalid    <= wvalid_d;
      bready    <= bready_d;
      arvalid   <= arvalid_d;
      rready    <= rready_d;
      rsp_valid <= rsp_valid_d;
      if (accept) begin
        addr_q     <= cmd_addr;
        wdata      <= cmd_wdata;
        rsp_write  <= cmd_write;
        rsp_rdata  <= '0;
        rsp_err    <= 1'b0;
        // the accept cycle itself is the first counted cycle
        rsp_cycles <= CNT_WIDTH'(1);
      end else if (busy) begin
        rsp_cycles <= sat_inc(rsp_cycles);
      end
      if (b_hs) rsp_err <= (wresp[1:0] != RESP_OKAY);
      if (r_hs) rsp_rdata <= rdata;
    end
  end

endmodule
